// File: rtl/gpio_checker.sv
// gpio_checker: compares successive gpio writes against a preloaded table.
// Optional idle timeout when GPIO_CHECKER_TIMEOUT_EN is defined.
module gpio_checker #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] gpio,
  input  logic                  exp_we,
  input  logic [ADDR_WIDTH-1:0] exp_waddr,
  input  logic [DATA_WIDTH-1:0] exp_wdata,
  input  logic [ADDR_WIDTH:0]   num_checks,
  input  logic                  start,
  output logic                  busy,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [ADDR_WIDTH-1:0] fail_index,
  output logic [DATA_WIDTH-1:0] fail_actual,
  output logic [ADDR_WIDTH:0]   match_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PASS,
    FAIL
  } state_t;

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] NMAX = (ADDR_WIDTH+1)'(DEPTH);

  state_t state, state_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] gpio_q;
  logic [DATA_WIDTH-1:0] last;
  logic [DATA_WIDTH-1:0] exp_rd;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH:0]   n_q;
  logic [ADDR_WIDTH:0]   n_sat;
  logic [ADDR_WIDTH:0]   last_idx;
  logic                  do_start;
  logic                  ev;
  logic                  hit;
  logic                  done;
  logic                  miss;
  logic                  tmo;

  assign n_sat    = (num_checks > NMAX) ? NMAX : num_checks;
  assign last_idx = n_q - (ADDR_WIDTH+1)'(1);
  assign exp_rd   = mem[idx];
  assign do_start = start && (state != RUN);
  assign ev       = (state == RUN) && (gpio_q != last);
  assign hit      = ev && (gpio_q == exp_rd);
  assign miss     = ev && !hit;
  assign done     = hit && ({1'b0, idx} == last_idx);

  assign busy = (state == RUN);
  assign pass = (state == PASS);
  assign fail = (state == FAIL);

`ifdef GPIO_CHECKER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          timeout_q;

  assign tmo     = (state == RUN) && !ev && (cnt == LIM);
  assign timeout = timeout_q;

  // idle counter: cleared by start or event, counts quiet RUN cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (do_start || ev) cnt <= '0;
      else if (state == RUN) cnt <= cnt + CW'(1);
      if (do_start) timeout_q <= 1'b0;
      else if (tmo) timeout_q <= 1'b1;
    end
  end
`else
  assign tmo     = 1'b0;
  assign timeout = 1'b0;
`endif

  // expected table: writable outside RUN, never reset
  always_ff @(posedge clk) begin
    if (exp_we && (state != RUN)) mem[exp_waddr] <= exp_wdata;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE, PASS, FAIL: begin
        if (start) state_d = (n_sat == '0) ? PASS : RUN;
      end
      RUN: begin
        if (done) state_d = PASS;
        else if (miss || tmo) state_d = FAIL;
      end
      default: state_d = IDLE;
    endcase
  end

  // datapath: gpio pipeline, index, match and failure capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_q      <= '0;
      last        <= '0;
      idx         <= '0;
      n_q         <= '0;
      match_count <= '0;
      fail_index  <= '0;
      fail_actual <= '0;
    end else begin
      gpio_q <= gpio;
      if (do_start) begin
        n_q         <= n_sat;
        last        <= gpio_q;
        idx         <= '0;
        match_count <= '0;
        fail_index  <= '0;
        fail_actual <= '0;
      end else if (ev) begin
        last <= gpio_q;
        if (hit) begin
          idx         <= idx + ADDR_WIDTH'(1);
          match_count <= match_count + (ADDR_WIDTH+1)'(1);
        end else begin
          fail_index  <= idx;
          fail_actual <= gpio_q;
        end
      end else if (tmo) begin
        fail_index  <= idx;
        fail_actual <= gpio_q;
      end
    end
  end

endmodule

// File: doc/gpio_checker.md
# gpio_checker

Synthesizable consumer for the CPU `gpio` output bus. It watches the 32-bit `gpio` word the core drives, detects each new value the program writes, and compares that sequence against a table of expected values loaded beforehand. It reports pass or fail with the failing index and actual value, so self-checking programs can run on hardware with no simulator. It sits beside `cpu` at top level and is driven only by `gpio`.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of `gpio` and of table entries
- `ADDR_WIDTH`, 5, log2 of expected-table depth (32 entries)
- `TIMEOUT_CYCLES`, 1024, idle-cycle limit between events (only with `GPIO_CHECKER_TIMEOUT_EN`)

Ports:
- `clk` in 1: system clock; all state changes on the rising edge
- `rst` in 1: asynchronous, active-high reset
- `gpio` in DATA_WIDTH: CPU gpio bus under check
- `exp_we` in 1: expected-table write enable
- `exp_waddr` in ADDR_WIDTH: table write address
- `exp_wdata` in DATA_WIDTH: table write data
- `num_checks` in ADDR_WIDTH+1: number of entries to check (0..2^ADDR_WIDTH); sampled on `start`
- `start` in 1: single-cycle pulse that arms the check
- `busy` out 1: high in RUN
- `pass` out 1: high in PASS
- `fail` out 1: high in FAIL
- `timeout` out 1: FAIL was caused by the idle limit
- `fail_index` out ADDR_WIDTH: table index of the first mismatch
- `fail_actual` out DATA_WIDTH: `gpio` value that mismatched
- `match_count` out ADDR_WIDTH+1: entries matched so far

## Operation
- States: IDLE, RUN, PASS, FAIL. Reset forces IDLE. All outputs reset to 0, along with `idx`, `gpio_q`, `last` and the timeout counter. Table contents are not reset.
- `gpio_q <= gpio` on every cycle in all states.
- Table writes take effect when `exp_we` is high in IDLE, PASS or FAIL. Writes in RUN are ignored.
- `start` in IDLE, PASS or FAIL causes the following:
  - latch `num_checks`
  - `last <= gpio_q`
  - clear `idx`, `match_count`, `fail_index`, `fail_actual`, `timeout`
  - go to RUN, or go straight to PASS if `num_checks`==0
- `start` in RUN is ignored.
- Event: in RUN, `gpio_q != last`. On an event, `last <= gpio_q` and the new value is compared with `exp[idx]`:
  - Match: `idx++`, `match_count++`. If `idx`==`num_checks`-1, go to PASS.
  - Mismatch: `fail_index <= idx`, `fail_actual <= gpio_q`, go to FAIL.
- A gpio write of a value equal to the previous value produces no event. Consecutive duplicate expected entries are therefore unsupported, and test programs must avoid them.
- Any number of gpio changes after PASS or FAIL is ignored. PASS and FAIL hold until `start` or `rst`.
- `num_checks` > 2^ADDR_WIDTH saturates to 2^ADDR_WIDTH.
- `rst` mid-RUN aborts to IDLE immediately (asynchronous). A re-`start` is required.

## Timing
- `gpio` change visible before edge k is registered into `gpio_q` at edge k. It is compared, and `idx`/state/outputs update, at edge k+1. Total latency: 2 cycles.
- A `gpio` value must be stable for at least 1 full cycle to be seen. Changes on back-to-back cycles are each detected.
- `start` at edge k: `busy` is high after edge k. With `num_checks`==0, `pass` is high after edge k.
- `pass`/`fail` and `busy` change on the same edge and are never high together.
- A table write at edge k is readable for comparison from edge k+1.

## Configuration
- `GPIO_CHECKER_TIMEOUT_EN` defined:
  - A counter clears on `start` and on every event, and increments each RUN cycle with no event.
  - When the counter reaches `TIMEOUT_CYCLES` it causes a transition to FAIL with `timeout`=1, `fail_index`=`idx`, `fail_actual`=`gpio_q`.
  - An event on the same cycle takes priority over the timeout.
- Not defined: no counter; `timeout` is tied 0; RUN waits indefinitely.

## Test plan
- Load `exp`={FFFFFFFF,1,6,7}, `num_checks`=4, start, drive gpio 0→FFFFFFFF→1→6→7 one value per 10 cycles -> `pass`=1, `match_count`=4, `busy`=0, 2 cycles after the last change.
- Same table, drive FFFFFFFF,1,5 -> `fail`=1, `fail_index`=2, `fail_actual`=5, `match_count`=2. Further gpio changes leave the outputs unchanged.
- `num_checks`=0, start -> `pass`=1 on the next cycle with gpio untouched.
- Changes on back-to-back cycles FFFFFF00,700A,7 against a matching table -> all three counted, `pass`=1.
- Assert `rst` mid-RUN after 2 matches -> IDLE immediately, all outputs 0. A re-`start` then checks from index 0.
- With `GPIO_CHECKER_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16: start, hold gpio constant -> `fail`=1, `timeout`=1, `fail_index`=0 exactly 16 cycles after start. Without the macro, `busy` stays 1.
